// File: rtl/adder4.sv
// adder4: 4-bit unsigned ripple-carry adder, {io_Cout, io_Sum} = io_A + io_B + io_Cin.
// The adder is a chain of four adder4_fa full-adder stages.
// Optional feature macro: ADDER4_OUTREG_EN
//   defined   -> outputs come from registers with one cycle of latency.
//                The registers clear asynchronously while reset is low.
//   undefined -> outputs are purely combinational.
//                The clock and reset ports are present but unused.

// Single-bit full adder used as one stage of the ripple chain.
module adder4_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  // Propagate term; it is shared by the sum and the carry.
  always_comb begin
    half = a ^ b;
    sum  = half ^ cin;
    cout = (a & b) | (cin & half);
  end

endmodule

// Top level: four ripple stages plus an optional output register.
module adder4 (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] io_A,
  input  logic [3:0] io_B,
  input  logic       io_Cin,
  output logic [3:0] io_Sum,
  output logic       io_Cout
);

  // c[0] is the carry-in.
  // c[i+1] is the carry out of stage i.
  // c[4] is the final carry-out.
  logic [4:0] c;
  logic [3:0] sum_comb;

  assign c[0] = io_Cin;

  // One full adder per bit.
  // Each stage's carry-out feeds the carry-in of the next stage.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
      adder4_fa u_fa (
        .a    (io_A[gi]),
        .b    (io_B[gi]),
        .cin  (c[gi]),
        .sum  (sum_comb[gi]),
        .cout (c[gi+1])
      );
    end
  endgenerate

`ifdef ADDER4_OUTREG_EN
  logic [3:0] sum_reg;
  logic       cout_reg;

  // Capture the adder result on every rising edge.
  // Reset low clears the registers at once, so no earlier result survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_reg  <= 4'd0;
      cout_reg <= 1'b0;
    end else begin
      sum_reg  <= sum_comb;
      cout_reg <= c[4];
    end
  end

  assign io_Sum  = sum_reg;
  assign io_Cout = cout_reg;
`else
  // Clock and reset have no function in this build.
  // They are folded into a deliberately unused net.
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;

  assign io_Sum  = sum_comb;
  assign io_Cout = c[4];
`endif

endmodule

// File: tb/tb_adder4.sv
// tb_adder4: directed and exhaustive checks of adder4.
// The bench works in both builds.
// Define ADDER4_OUTREG_EN here as well to exercise the registered build.
module tb_adder4;

  logic       clock;
  logic       reset;
  logic [3:0] io_A;
  logic [3:0] io_B;
  logic       io_Cin;
  logic [3:0] io_Sum;
  logic       io_Cout;

  int vectors_applied;
  int miscompares;

  adder4 dut (
    .clock   (clock),
    .reset   (reset),
    .io_A    (io_A),
    .io_B    (io_B),
    .io_Cin  (io_Cin),
    .io_Sum  (io_Sum),
    .io_Cout (io_Cout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare {Cout, Sum} with the expected value and print one line per transaction.
  task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got cout=%0b sum=%0d, want cout=%0b sum=%0d",
               tag, observed[4], observed[3:0], expected[4], expected[3:0]);
    end else begin
      $display("ok   %s: cout=%0b sum=%0d", tag, observed[4], observed[3:0]);
    end
  endtask

  // Drive one operand set.
  // Then wait until the result is valid: after the next edge in the registered build,
  // or after a short settle time in the combinational build.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
    io_A   = a;
    io_B   = b;
    io_Cin = cin;
`ifdef ADDER4_OUTREG_EN
    @(posedge clock);
    #1;
`else
    #1;
`endif
  endtask

  // Directed vectors: A, B, Cin and the hand-computed {Cout, Sum}.
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd15, 4'd15, 1'b1, 5'd31};  // maximum
    vecs[1] = '{4'd0,  4'd0,  1'b0, 5'd0};   // zero
    vecs[2] = '{4'd15, 4'd0,  1'b1, 5'd16};  // wrap-around
    vecs[3] = '{4'd15, 4'd0,  1'b0, 5'd15};  // ripple, before carry-in
    vecs[4] = '{4'd8,  4'd8,  1'b0, 5'd16};  // MSB carry only
    vecs[5] = '{4'd3,  4'd4,  1'b1, 5'd8};
    vecs[6] = '{4'd7,  4'd9,  1'b0, 5'd16};
    vecs[7] = '{4'd5,  4'd10, 1'b0, 5'd15};  // no carries
    vecs[8] = '{4'd6,  4'd6,  1'b1, 5'd13};
    vecs[9] = '{4'd1,  4'd1,  1'b1, 5'd3};

    vectors_applied = 0;
    miscompares     = 0;
    io_A   = 4'd0;
    io_B   = 4'd0;
    io_Cin = 1'b0;
    reset  = 1'b0;

`ifdef ADDER4_OUTREG_EN
    // Registers hold 0 while reset is low, even across clock edges.
    io_A = 4'd9;
    io_B = 4'd2;
    @(posedge clock);
    #1;
    check("reset_hold", {io_Cout, io_Sum}, 5'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("before_first_edge", {io_Cout, io_Sum}, 5'd0);
    @(posedge clock);
    #1;
    check("first_capture", {io_Cout, io_Sum}, 5'd11);
`else
    // Without the register stage, reset has no effect on the outputs.
    io_A   = 4'd6;
    io_B   = 4'd6;
    io_Cin = 1'b1;
    #1;
    check("reset_low_no_effect", {io_Cout, io_Sum}, 5'd13);
    reset = 1'b1;
    #1;
    check("reset_high", {io_Cout, io_Sum}, 5'd13);
`endif

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("dir%0d_%0d+%0d+%0d", i, vecs[i].a, vecs[i].b, vecs[i].cin),
            {io_Cout, io_Sum}, vecs[i].exp);
    end

    // Carry ripple: 15+0+0, then the same operands with carry-in.
    apply(4'd15, 4'd0, 1'b0);
    check("ripple_cin0", {io_Cout, io_Sum}, 5'd15);
    apply(4'd15, 4'd0, 1'b1);
    check("ripple_cin1", {io_Cout, io_Sum}, 5'd16);

`ifdef ADDER4_OUTREG_EN
    // Latency: the new operands must not appear before the edge.
    // The previous result is 16.
    io_A   = 4'd3;
    io_B   = 4'd4;
    io_Cin = 1'b1;
    #2;
    check("latency_before_edge", {io_Cout, io_Sum}, 5'd16);
    @(posedge clock);
    #1;
    check("latency_after_edge", {io_Cout, io_Sum}, 5'd8);

    // Reset mid-operation: first reach Sum=13.
    apply(4'd6, 4'd6, 1'b1);
    check("pre_reset_13", {io_Cout, io_Sum}, 5'd13);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", {io_Cout, io_Sum}, 5'd0);
    @(posedge clock);
    #1;
    check("held_in_reset", {io_Cout, io_Sum}, 5'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("released_no_edge", {io_Cout, io_Sum}, 5'd0);
    @(posedge clock);
    #1;
    check("post_reset_capture", {io_Cout, io_Sum}, 5'd13);
`endif

    // Exhaustive sweep of all 512 operand combinations.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [4:0] exp;
          exp = 5'(a) + 5'(b) + 5'(ci);
          apply(4'(a), 4'(b), 1'(ci));
          check($sformatf("sweep_%0d+%0d+%0d", a, b, ci), {io_Cout, io_Sum}, exp);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/adder4.md
ADDER4 -- requirements
Module: adder4

Interface
REQ-001 The block SHALL have exactly one clock and one reset, and reset SHALL be asynchronous and active-low.
REQ-002 Port clock, input, 1 bit: the only clock; rising edge active.
REQ-003 Port reset, input, 1 bit: asynchronous active-low reset (0 = in reset).
REQ-004 Port io_A, input, 4 bits: addend A, unsigned.
REQ-005 Port io_B, input, 4 bits: addend B, unsigned.
REQ-006 Port io_Cin, input, 1 bit: carry-in.
REQ-007 Port io_Sum, output, 4 bits: low 4 bits of A+B+Cin.
REQ-008 Port io_Cout, output, 1 bit: carry-out, bit 4 of A+B+Cin.
REQ-009 The block SHALL have no parameters; all widths are fixed at 4 bits.

Function
REQ-010 The block SHALL compute {io_Cout, io_Sum} = io_A + io_B + io_Cin as an unsigned 5-bit result; no truncation other than the 5-bit result width.
REQ-011 The adder SHALL be a 4-stage ripple-carry chain: stage i takes A[i], B[i] and carry c[i], with c[0] = io_Cin, and produces Sum[i] and c[i+1]; io_Cout = c[4].
REQ-012 Each stage SHALL be a full adder: Sum[i] = A[i] xor B[i] xor c[i]; c[i+1] = (A[i] and B[i]) or (c[i] and (A[i] xor B[i])).
REQ-013 The full adder SHALL be a separate submodule instantiated 4 times; the submodule SHALL NOT share a name with adder4.
REQ-014 With ADDER4_OUTREG_EN undefined, io_Sum and io_Cout SHALL be purely combinational functions of io_A, io_B, io_Cin: zero-cycle latency, independent of clock and reset.
REQ-015 With ADDER4_OUTREG_EN defined, io_Sum and io_Cout SHALL be driven from registers that capture the REQ-010 result on each rising clock edge: one-cycle latency, updated every cycle, with no enable or handshake.
REQ-016 Boundary conditions:
- 15+15+1 SHALL give Sum=15, Cout=1.
- 0+0+0 SHALL give Sum=0, Cout=0.
- Wrap-around 15+0+1 SHALL give Sum=0, Cout=1.
REQ-017 X or Z on any input SHALL NOT be specially handled; results follow normal RTL semantics.

Reset
REQ-018 Without ADDER4_OUTREG_EN, reset SHALL have no effect on the outputs.
REQ-019 With ADDER4_OUTREG_EN, reset=0 SHALL immediately and asynchronously force io_Sum=0 and io_Cout=0, independent of clock.
REQ-020 With ADDER4_OUTREG_EN, the output registers SHALL hold 0 while reset is low; the first capture SHALL occur on the first rising clock edge after reset goes high.
REQ-021 With ADDER4_OUTREG_EN, reset asserted mid-operation SHALL discard the in-flight result with no residual state.

Configuration
REQ-022 The macro ADDER4_OUTREG_EN SHALL select the output-register stage.
- Defined: REQ-015 and REQ-019 to REQ-021 apply.
- Undefined: REQ-014 and REQ-018 apply; clock and reset ports remain present but unused.
REQ-023 Function (REQ-010 to REQ-013) SHALL be identical in both configurations apart from latency.

Verification
REQ-024 Exhaustive sweep: all 512 combinations of A, B and Cin -> {Cout,Sum} equals A+B+Cin; checked combinationally (macro off) and one cycle later (macro on).
REQ-025 Carry ripple: A=15, B=0, Cin=0, then Cin=1 -> Sum=15, Cout=0, then Sum=0, Cout=1.
REQ-026 Maximum: A=15, B=15, Cin=1 -> Sum=15, Cout=1; A=8, B=8, Cin=0 -> Sum=0, Cout=1.
REQ-027 Latency (macro on): A=3, B=4, Cin=1 applied before edge N -> outputs 0 or the prior result before edge N, and Sum=8, Cout=0 after edge N.
REQ-028 Reset mid-operation (macro on): outputs at Sum=13 -> reset=0 between clock edges -> outputs read 0 immediately and stay 0 until the first edge after reset=1.
